// File: rtl/mul_product_frame_accumulator.sv
// ============================================================================
// mul_product_frame_accumulator
// ----------------------------------------------------------------------------
// Purpose:
//   Downstream stage of the signed DSP multiplier. It sums FRAME_LEN
//   consecutive signed products (a dot product per frame) and presents each
//   frame sum through a valid/ready output register. When a finished sum
//   cannot be delivered yet, it stalls the last beat of the following frame.
//
// Parameters:
//   P_W        width of the signed product input (default 38)
//   ACC_W      width of the signed accumulator and acc_o (ACC_W >= P_W)
//   FRAME_LEN  products per frame, legal range 2..65536
//
// Ports:
//   clk          in   rising-edge clock for all state
//   reset        in   synchronous, active-high reset
//   p_i          in   signed product from the multiplier
//   p_valid_i    in   p_i is valid this cycle
//   p_ready_o    out  block can accept p_i this cycle (combinational)
//   acc_o        out  signed frame sum
//   acc_valid_o  out  acc_o holds an undelivered frame sum
//   acc_ready_i  in   downstream accepts acc_o this cycle
//   ovf_o        out  overflow flag for the frame in acc_o
//
// Configuration macro:
//   ACC_SATURATE_EN  defined   -> every add saturates to the signed ACC_W
//                                 range, a per-frame sticky flag records any
//                                 saturation and is reported on ovf_o.
//                    undefined -> adds wrap modulo 2^ACC_W, ovf_o is tied 0.
// ============================================================================
module mul_product_frame_accumulator #(
  parameter int P_W       = 38,
  parameter int ACC_W     = 48,
  parameter int FRAME_LEN = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [P_W-1:0]   p_i,
  input  logic             p_valid_i,
  output logic             p_ready_o,
  output logic [ACC_W-1:0] acc_o,
  output logic             acc_valid_o,
  input  logic             acc_ready_i,
  output logic             ovf_o
);

  // FRAME_LEN >= 2, so $clog2 is at least 1 and the counter always exists.
  localparam int              CNT_W    = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q,       cnt_d;        // beat index within the frame
  logic [ACC_W-1:0] acc_q,       acc_d;        // running partial sum
  logic [ACC_W-1:0] out_q,       out_d;        // delivered frame sum
  logic             out_valid_q, out_valid_d;  // out_q not yet taken

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic             is_first;
  logic             is_last;
  logic             accept;
  logic [ACC_W-1:0] p_ext;     // sign-extended product
  logic [ACC_W-1:0] sum;       // acc_q + p_ext, wrapped or clamped
  logic             sat;       // this add saturated (always 0 when wrapping)

  assign is_first = (cnt_q == '0);
  assign is_last  = (cnt_q == LAST_CNT);

  // Only the last beat can stall: it would overwrite an undelivered sum.
  // Beats 0..FRAME_LEN-2 never touch the output register.
  assign p_ready_o = !(is_last && out_valid_q && !acc_ready_i);
  assign accept    = p_valid_i && p_ready_o;

  // Signed cast before the size cast makes the extension replicate the sign.
  assign p_ext = ACC_W'($signed(p_i));

`ifdef ACC_SATURATE_EN
  // One guard bit holds the true sign of the sum; overflow occurred when the
  // guard bit disagrees with the ACC_W sign bit.
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] sat_max;
  logic [ACC_W-1:0] sat_min;
  logic             sticky_q, sticky_d;   // any saturation so far this frame
  logic             ovf_q,    ovf_d;      // overflow of the frame in out_q

  assign sat_max  = {1'b0, {(ACC_W-1){1'b1}}};
  assign sat_min  = {1'b1, {(ACC_W-1){1'b0}}};
  assign sum_wide = {acc_q[ACC_W-1], acc_q} + {p_ext[ACC_W-1], p_ext};
  assign sat      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

  always_comb begin
    // NOTE: every signal driven from an always_comb gets a default on entry;
    // a path that leaves one unassigned would infer a latch.
    sum = sum_wide[ACC_W-1:0];
    if (sat) begin
      sum = sum_wide[ACC_W] ? sat_min : sat_max;
    end
  end

  always_comb begin
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
    if (accept) begin
      // A load cannot saturate (ACC_W >= P_W), so frame start clears the flag.
      sticky_d = is_first ? 1'b0 : (sticky_q | sat);
      // FRAME_LEN >= 2 means the last beat is always an add, never a load.
      if (is_last) begin
        ovf_d = sticky_q | sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
    end
  end

  assign ovf_o = ovf_q;
`else
  // Plain modulo-2^ACC_W accumulation; no overflow tracking is built.
  assign sum   = acc_q + p_ext;
  assign sat   = 1'b0;
  assign ovf_o = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic: beat counter, accumulator, output register
  // --------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    out_d = out_q;
    // A pending sum is released by acc_ready_i; a new last beat below can
    // refill it on the same edge, keeping valid high with the new value.
    out_valid_d = out_valid_q && !acc_ready_i;

    if (accept) begin
      acc_d = is_first ? p_ext : sum;
      if (is_last) begin
        cnt_d       = '0;
        out_d       = sum;
        out_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments only, so every
    // register samples the values from before the edge regardless of order.
    if (reset) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign acc_o       = out_q;
  assign acc_valid_o = out_valid_q;

endmodule

// File: doc/mul_product_frame_accumulator.md
# mul_product_frame_accumulator

Downstream stage of the signed DSP multiplier. It consumes the registered 38-bit signed product stream, sums a fixed number of consecutive products per frame (a dot product), and presents each frame sum through a valid/ready output register. It applies backpressure to the multiplier side when a finished sum cannot yet be delivered.

## Interface
Parameters:
- `P_W`, 38, width of the signed product input.
- `ACC_W`, 48, width of the signed accumulator and of `acc_o`. Must satisfy `ACC_W >= P_W`.
- `FRAME_LEN`, 16, number of products per frame. Legal range 2..65536.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `p_i`  in  P_W  signed product from the multiplier.
- `p_valid_i`  in  1  `p_i` is valid this cycle.
- `p_ready_o`  out  1  block can accept `p_i` this cycle.
- `acc_o`  out  ACC_W  signed frame sum.
- `acc_valid_o`  out  1  `acc_o` holds an undelivered frame sum.
- `acc_ready_i`  in  1  downstream accepts `acc_o` this cycle.
- `ovf_o`  out  1  overflow flag for the frame in `acc_o`; valid while `acc_valid_o` is 1.

## Operation
- **Input beat.** A beat is accepted on a rising edge where `p_valid_i && p_ready_o`. Cycles where `p_valid_i` is 0 are ignored and do not advance state.
- **Sign extension.** `p_i` is sign-extended to `ACC_W` before any add.
- **Beat counter.** `cnt` runs 0..FRAME_LEN-1. It increments on each accepted beat and wraps to 0 after the last beat.
- **Accumulator update.** `acc` is the running sum.
  - Beat with `cnt == 0`: `acc` is loaded with `sext(p_i)`.
  - Other beats: `acc` becomes `acc + sext(p_i)`.
- **Last beat** (`cnt == FRAME_LEN-1`):
  - `acc_o` is loaded with the final sum, `acc + sext(p_i)`.
  - `ovf_o` is loaded with the frame's overflow status.
  - `acc_valid_o` is set to 1.
  - `acc` and `cnt` restart with the next beat.
- **Output handshake.**
  - `acc_valid_o` clears on an edge where `acc_ready_i` is 1, unless a new last beat is accepted on the same edge.
  - On that simultaneous edge the new sum is loaded and `acc_valid_o` stays 1.
  - `acc_o` and `ovf_o` stay stable while `acc_valid_o && !acc_ready_i`.
- **Backpressure** (combinational): `p_ready_o = !(cnt == FRAME_LEN-1 && acc_valid_o && !acc_ready_i)`. Only the last beat of a frame can stall; beats 0..FRAME_LEN-2 are always accepted.
- **Reset mid-frame.** The partial sum is discarded and any pending output is dropped.

## Timing
- **Reset values:** `acc_o` = 0, `acc_valid_o` = 0, `ovf_o` = 0, `acc` = 0, `cnt` = 0. `p_ready_o` is 1 after reset.
- **Latency:** `acc_valid_o` rises on the edge that accepts the last beat, i.e. it is visible 1 cycle after that beat is presented.
- **Throughput:** one product per cycle, with no bubble between frames as long as `acc_ready_i` is 1.
- **Stall release:** a last beat that stalls is accepted on the first edge where `acc_ready_i` is 1. That edge delivers the old sum and loads the new one.

## Configuration
Macro `ACC_SATURATE_EN`:
- **Defined:**
  - Every add saturates to the signed range of `ACC_W`: +2^(ACC_W-1)-1 or -2^(ACC_W-1).
  - An internal sticky flag is set on any saturation within the frame and is cleared at frame start.
  - On the last beat the flag is copied to `ovf_o`.
  - Once saturated, later adds continue from the clamped value.
- **Undefined:**
  - Adds wrap modulo 2^ACC_W.
  - `ovf_o` is tied to 0.
  - No saturation logic is synthesized.

## Test plan
- **Reset.** Hold `reset` for 2 cycles -> `acc_o` = 0, `acc_valid_o` = 0, `ovf_o` = 0, `p_ready_o` = 1.
- **Basic frame.** `FRAME_LEN` = 4, back-to-back `p_i` = 10, -3, 7, 100, `acc_ready_i` = 1 -> `acc_o` = 114 and `acc_valid_o` = 1 for exactly 1 cycle after the 4th beat.
- **Backpressure.** `FRAME_LEN` = 4, `acc_ready_i` = 0. Frame 1 of 1,1,1,1, then frame 2 of 2,2,2,2 -> `acc_o` = 4 held stable, and `p_ready_o` = 0 while the 4th beat of frame 2 is presented. Raise `acc_ready_i` -> 4 delivered, then `acc_o` = 8.
- **Gapped input.** `FRAME_LEN` = 4, `p_valid_i` toggling every cycle, `p_i` = -5 on valid cycles -> `acc_o` = -20 after 4 accepted beats.
- **Overflow.** `ACC_W` = 40, `FRAME_LEN` = 16, all `p_i` = 2^37-1.
  - With `ACC_SATURATE_EN`: `acc_o` = 549755813887, `ovf_o` = 1.
  - Without it: `acc_o` = -16, `ovf_o` = 0.
- **Reset mid-frame.** `FRAME_LEN` = 4: accept 2 beats of 50, assert `reset` for 1 cycle, then send 1,2,3,4 -> `acc_o` = 10 and no output for the aborted frame.
